// File: rtl/cpu_periferico_link_if.sv
// cpu_periferico_link_if: exported send/ack handshake and data signals of the CPU/peripheral link.
interface cpu_periferico_link_if #(
    parameter int DATA_WIDTH  = 4,
    parameter int COUNT_WIDTH = 8
);
    logic                   cpu_send;
    logic                   per_ack;
    logic [DATA_WIDTH-1:0]  cpu_dados;
    logic [DATA_WIDTH-1:0]  per_dados;
    logic                   per_valid;
    logic [COUNT_WIDTH-1:0] per_count;
    modport master (output cpu_send, per_ack, cpu_dados, per_dados, per_valid, per_count);
    modport slave  (input  cpu_send, per_ack, cpu_dados, per_dados, per_valid, per_count);
endinterface

// File: rtl/cpu_periferico_link.sv
// cpu_periferico_link: CPU-side sender and peripheral-side receiver FSMs exchanging an
// incrementing word over a 4-phase send/ack handshake; all outputs registered.
module cpu_periferico_link #(
    parameter int DATA_WIDTH  = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                 cpu_clock,
    input  logic                 cpu_reset,
    cpu_periferico_link_if.master bus
);
    typedef enum logic [1:0] {C_REQ, C_WAIT_ACK, C_WAIT_REL} c_state_t;
    typedef enum logic {P_IDLE, P_ACK} p_state_t;

    c_state_t               c_state_q;
    p_state_t               p_state_q;
    logic                   send_q;
    logic                   ack_q;
    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  cpu_dados_q;
    logic [DATA_WIDTH-1:0]  per_dados_q;
    logic [COUNT_WIDTH-1:0] count_q;

    // The word only advances once ack has dropped, so it is stable for the whole send phase.
    always_ff @(posedge cpu_clock or posedge cpu_reset) begin
        if (cpu_reset) begin
            c_state_q   <= C_REQ;
            send_q      <= 1'b0;
            cpu_dados_q <= '0;
        end else begin
            case (c_state_q)
                C_REQ: if (!ack_q) begin
                    send_q    <= 1'b1;
                    c_state_q <= C_WAIT_ACK;
                end
                C_WAIT_ACK: if (ack_q) begin
                    send_q    <= 1'b0;
                    c_state_q <= C_WAIT_REL;
                end
                C_WAIT_REL: if (!ack_q) begin
                    cpu_dados_q <= cpu_dados_q + 1'b1;
                    c_state_q   <= C_REQ;
                end
                default: begin
                    send_q    <= 1'b0;
                    c_state_q <= C_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clock or posedge cpu_reset) begin
        if (cpu_reset) begin
            p_state_q   <= P_IDLE;
            ack_q       <= 1'b0;
            valid_q     <= 1'b0;
            per_dados_q <= '0;
            count_q     <= '0;
        end else begin
            case (p_state_q)
                P_IDLE: if (send_q) begin
                    per_dados_q <= cpu_dados_q;
                    ack_q       <= 1'b1;
                    valid_q     <= 1'b1;
                    count_q     <= count_q + 1'b1;
                    p_state_q   <= P_ACK;
                end
                P_ACK: begin
                    valid_q <= 1'b0;
                    if (!send_q) begin
                        ack_q     <= 1'b0;
                        p_state_q <= P_IDLE;
                    end
                end
                default: p_state_q <= P_IDLE;
            endcase
        end
    end

    assign bus.cpu_send  = send_q;
    assign bus.per_ack   = ack_q;
    assign bus.cpu_dados = cpu_dados_q;
    assign bus.per_dados = per_dados_q;
    assign bus.per_valid = valid_q;
    assign bus.per_count = count_q;
endmodule

// File: tb/tb_cpu_periferico_link.sv
// tb_cpu_periferico_link: scenario tasks plus a free-running handshake monitor that
// models the link as "the n-th latch since reset carries word n-1 and count n".
module tb_cpu_periferico_link;
    localparam int DW = 4;
    localparam int CW = 8;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    cpu_periferico_link_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    cpu_periferico_link #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .cpu_clock (clk),
        .cpu_reset (rst),
        .bus       (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Reference model: latches since reset define the expected word and count.
    logic          p_send, p_ack;
    logic [DW-1:0] p_dados;
    int            m_latches;

    initial begin
        p_send = 0; p_ack = 0; p_dados = '0; m_latches = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                p_send = 0; p_ack = 0; p_dados = '0; m_latches = 0;
            end else begin
                total++;
                if (bus.per_ack && !p_ack && !p_send) begin
                    bad++;
                    $display("FAIL ack_rise_without_send: ack=%0b prev_send=%0b required prev_send=1", bus.per_ack, p_send);
                end
                if (bus.cpu_send && !p_send && p_ack) begin
                    bad++;
                    $display("FAIL send_rise_with_ack: prev_ack=%0b required 0", p_ack);
                end
                if (bus.per_valid !== (bus.per_ack && !p_ack)) begin
                    bad++;
                    $display("FAIL valid_vs_ack_rise: per_valid=%0b required %0b", bus.per_valid, bus.per_ack && !p_ack);
                end
                if (p_send && bus.cpu_send && bus.cpu_dados !== p_dados) begin
                    bad++;
                    $display("FAIL dados_stable: cpu_dados=%0d required %0d", bus.cpu_dados, p_dados);
                end
                if (bus.per_valid) begin
                    if (bus.per_dados !== DW'(m_latches) || bus.per_count !== CW'(m_latches + 1)) begin
                        bad++;
                        $display("FAIL latch_model: per_dados=%0d per_count=%0d required %0d %0d",
                                 bus.per_dados, bus.per_count, DW'(m_latches), CW'(m_latches + 1));
                    end
                    m_latches++;
                end
                p_send  = bus.cpu_send;
                p_ack   = bus.per_ack;
                p_dados = bus.cpu_dados;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if ({bus.cpu_send, bus.per_ack, bus.cpu_dados, bus.per_dados, bus.per_valid, bus.per_count} !== '0) begin
            bad++;
            $display("FAIL reset_zero: send=%0b ack=%0b dados=%0d pdados=%0d valid=%0b count=%0d required all 0",
                     bus.cpu_send, bus.per_ack, bus.cpu_dados, bus.per_dados, bus.per_valid, bus.per_count);
        end
        #3 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.cpu_send !== 1'b1 || bus.per_ack !== 1'b0) begin
            bad++;
            $display("FAIL e1: send=%0b ack=%0b required 1 0", bus.cpu_send, bus.per_ack);
        end
        @(posedge clk); #1;
        total++;
        if (bus.per_ack !== 1'b1 || bus.per_dados !== '0 || bus.per_valid !== 1'b1 || bus.per_count !== CW'(1)) begin
            bad++;
            $display("FAIL e2: ack=%0b pdados=%0d valid=%0b count=%0d required 1 0 1 1",
                     bus.per_ack, bus.per_dados, bus.per_valid, bus.per_count);
        end
    endtask

    task automatic test_free_run();
        int nv = 0, last = 0, first = 0, gap_err = 0;
        @(posedge clk); #2 rst = 1'b1; #6 rst = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (bus.per_valid) begin
                if (nv == 0) first = c;
                else if (c - last != 5) gap_err++;
                last = c;
                nv++;
            end
        end
        total++;
        if (nv != 10 || first != 2 || gap_err != 0) begin
            bad++;
            $display("FAIL free_run_pulses: count=%0d first=%0d gap_errors=%0d required 10 2 0", nv, first, gap_err);
        end
        total++;
        if (bus.per_dados !== DW'(9) || bus.per_count !== CW'(10)) begin
            bad++;
            $display("FAIL free_run_final: pdados=%0d count=%0d required 9 10", bus.per_dados, bus.per_count);
        end
    endtask

    task automatic test_data_wrap();
        int words[$];
        int cyc = 0;
        @(posedge clk); #2 rst = 1'b1; #6 rst = 1'b0;
        while (words.size() < 17 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.per_valid) words.push_back(int'(bus.per_dados));
        end
        total++;
        if (words.size() != 17) begin
            bad++;
            $display("FAIL wrap_timeout: latched=%0d required 17", words.size());
        end else begin
            total++;
            if (words[14] != 14 || words[15] != 15 || words[16] != 0 || bus.per_count !== CW'(17)) begin
                bad++;
                $display("FAIL wrap_tail: %0d %0d %0d count=%0d required 14 15 0 17",
                         words[14], words[15], words[16], bus.per_count);
            end
            repeat (3) @(posedge clk);
            #1;
            total++;
            if (bus.cpu_dados !== DW'(1)) begin
                bad++;
                $display("FAIL wrap_cpu_dados: cpu_dados=%0d required 1", bus.cpu_dados);
            end
        end
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        int first = 0;
        @(negedge clk);
        while (!(bus.cpu_send && bus.per_ack) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!(bus.cpu_send && bus.per_ack)) begin
            bad++;
            $display("FAIL midshake_timeout: send=%0b ack=%0b required 1 1", bus.cpu_send, bus.per_ack);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.cpu_send, bus.per_ack, bus.cpu_dados, bus.per_dados, bus.per_valid, bus.per_count} !== '0) begin
            bad++;
            $display("FAIL async_reset_zero: send=%0b ack=%0b dados=%0d pdados=%0d valid=%0b count=%0d required all 0",
                     bus.cpu_send, bus.per_ack, bus.cpu_dados, bus.per_dados, bus.per_valid, bus.per_count);
        end
        #1 rst = 1'b0;
        for (int c = 1; c <= 10 && first == 0; c++) begin
            @(posedge clk); #1;
            if (bus.per_valid) first = c;
        end
        total++;
        if (first != 2 || bus.per_dados !== '0 || bus.per_count !== CW'(1)) begin
            bad++;
            $display("FAIL async_restart: at=%0d pdados=%0d count=%0d required 2 0 1", first, bus.per_dados, bus.per_count);
        end
    endtask

    task automatic test_random_resets();
        for (int i = 0; i < 6; i++) begin
            int n = $urandom_range(3, 40);
            int a = $urandom_range(1, 7);
            int seen = 0;
            repeat (n) @(posedge clk);
            #a rst = 1'b1;
            #1;
            total++;
            if ({bus.cpu_send, bus.per_ack, bus.cpu_dados, bus.per_dados, bus.per_valid, bus.per_count} !== '0) begin
                bad++;
                $display("FAIL rand_reset_zero: iter=%0d send=%0b ack=%0b dados=%0d count=%0d required all 0",
                         i, bus.cpu_send, bus.per_ack, bus.cpu_dados, bus.per_count);
            end
            #(8 - a) rst = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(posedge clk); #1;
                seen = int'(bus.per_valid);
            end
            total++;
            if (!seen || bus.per_dados !== '0 || bus.per_count !== CW'(1)) begin
                bad++;
                $display("FAIL rand_restart: iter=%0d seen=%0d pdados=%0d count=%0d required 1 0 1",
                         i, seen, bus.per_dados, bus.per_count);
            end
        end
    endtask

    task automatic test_count_wrap();
        int nv = 0, cyc = 0;
        @(posedge clk); #2 rst = 1'b1; #6 rst = 1'b0;
        while (nv < 256 && cyc < 1400) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.per_valid) nv++;
        end
        total++;
        if (nv != 256 || bus.per_count !== '0) begin
            bad++;
            $display("FAIL count_wrap: latched=%0d count=%0d required 256 0", nv, bus.per_count);
        end
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus.per_valid && cyc < 10);
        total++;
        if (!bus.per_valid || cyc != 5 || bus.per_count !== CW'(1) || bus.per_dados !== '0) begin
            bad++;
            $display("FAIL count_after_wrap: valid=%0b gap=%0d count=%0d pdados=%0d required 1 5 1 0",
                     bus.per_valid, cyc, bus.per_count, bus.per_dados);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_data_wrap();
        test_async_reset();
        test_random_resets();
        test_count_wrap();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_periferico_link.md
Name: cpu_periferico_link

Overview:
- Self-contained transfer block with two communicating FSMs on one clock: a CPU-side sender and a PERIFERICO-side receiver.
- The CPU side generates an incrementing data word. It delivers each word to the peripheral side over a 4-phase send/ack handshake.
- The peripheral side latches each word and counts completed receptions.
- Sits at the top of the CPU/peripheral subsystem. Its handshake and data signals are exported for observation.

Parameters:
- DATA_WIDTH, 4, width of the transferred data word (cpu_dados, per_dados).
- COUNT_WIDTH, 8, width of the reception counter per_count.

Ports:
- cpu_clock  input  1  single clock; all state updates on its rising edge.
- cpu_reset  input  1  asynchronous, active-high reset for both FSMs.
- cpu_send  output  1  CPU request: data on cpu_dados is valid while high.
- per_ack  output  1  peripheral acknowledge: data has been latched.
- cpu_dados  output  DATA_WIDTH  word currently offered by the CPU.
- per_dados  output  DATA_WIDTH  last word latched by the peripheral.
- per_valid  output  1  one-cycle pulse in the cycle per_dados is updated.
- per_count  output  COUNT_WIDTH  number of words received, modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (async, immediate, any state):
  - cpu_send=0, per_ack=0, cpu_dados=0, per_dados=0, per_valid=0, per_count=0.
  - CPU FSM goes to C_REQ; peripheral FSM goes to P_IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- CPU FSM, states C_REQ, C_WAIT_ACK, C_WAIT_REL:
  - C_REQ: if per_ack==0 then cpu_send<=1, go to C_WAIT_ACK; otherwise hold.
  - C_WAIT_ACK: if per_ack==1 then cpu_send<=0, go to C_WAIT_REL; otherwise hold, with cpu_send=1 and cpu_dados stable.
  - C_WAIT_REL: if per_ack==0 then cpu_dados<=cpu_dados+1, go to C_REQ; otherwise hold.
  - cpu_dados changes only in the C_WAIT_REL->C_REQ transition, so it is stable whenever cpu_send=1.
- Peripheral FSM, states P_IDLE, P_ACK:
  - P_IDLE: if cpu_send==1 then:
    - per_dados<=cpu_dados, per_ack<=1, per_valid<=1;
    - per_count<=per_count+1;
    - go to P_ACK.
  - P_ACK: per_valid<=0. If cpu_send==0 then per_ack<=0, go to P_IDLE; otherwise hold per_ack=1.
  - per_valid is 0 in every cycle other than the latch cycle.
- Cycle timing after reset deassertion (edge 1 = first rising edge with reset low):
  - E1: cpu_send=1.
  - E2: per_ack=1, per_dados=0, per_valid=1, per_count=1.
  - E3: cpu_send=0, per_valid=0.
  - E4: per_ack=0.
  - E5: cpu_dados=1.
  - E6: cpu_send=1, and the sequence repeats.
  - One word completes every 5 cycles.
- Arithmetic:
  - cpu_dados wraps modulo 2^DATA_WIDTH (15 -> 0 for the default).
  - per_count wraps modulo 2^COUNT_WIDTH (255 -> 0).
- Invariants:
  - per_ack never rises while cpu_send=0.
  - cpu_send never rises while per_ack=1.
  - Each word is latched exactly once.
  - Received data equals the sent sequence 0,1,2,... with no gaps or duplicates.
- Reset mid-handshake (e.g. cpu_send=1, per_ack=1): both sides return to their reset values. The next transfer restarts with word 0 and per_count restarts from 0.

Test Plan:
- Reset held 5 time units, then released -> during reset all outputs are 0. At E1 cpu_send=1; at E2 per_ack=1, per_dados=0, per_valid=1, per_count=1.
- Free run 50 cycles after reset -> 10 transfers complete. per_dados steps 0..9, per_count=10, and per_valid pulses exactly 10 times, each 5 cycles apart.
- Continuous run of 17 transfers -> per_dados sequence ends ...,14,15,0. At completion per_count=17 and cpu_dados=1.
- Handshake checker over any run:
  - cpu_dados never changes while cpu_send=1;
  - send/ack follow the order send^ ack^ send_v ack_v;
  - per_valid is high in exactly the cycles where per_ack rises.
- Assert cpu_reset asynchronously (between clock edges) while cpu_send=1 and per_ack=1 -> all outputs are 0 immediately, before the next clock edge. After release, the first latched word is 0 and per_count=1.
- Run 256 transfers -> per_count wraps to 0. The next latch sets per_count=1.
